// File: rtl/decode_pkg.sv
// Shared definitions for the N-lane decode stage: instruction field
// positions, the zero register, and forward-select encodings.
package decode_pkg;

  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam int REG_ZERO = 0;

  // Forward select: FWD_RF takes the regfile, FWD_M_BASE+k takes M-stage lane k.
  localparam int FWD_RF     = 0;
  localparam int FWD_M_BASE = 1;

endpackage

// File: rtl/decode_regfile_mp.sv
// Multi-port register file: one write port and one read pair per lane,
// highest-lane write priority, write-through reads, async active-low reset.
module decode_regfile_mp
  import decode_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORTS-1:0]      we,
  input  logic [NPORTS*AW-1:0]   waddr,
  input  logic [NPORTS*XLEN-1:0] wdata,
  input  logic [NPORTS*AW-1:0]   raddr_a,
  input  logic [NPORTS*AW-1:0]   raddr_b,
  output logic [NPORTS*XLEN-1:0] rdata_a,
  output logic [NPORTS*XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [NREGS];

  // Ascending port order: the last non-blocking write to an entry wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (we[p] && waddr[AW*p +: AW] != AW'(REG_ZERO))
          regs[waddr[AW*p +: AW]] <= wdata[XLEN*p +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_rd
    logic [AW-1:0]   ra, rb;
    logic [XLEN-1:0] va, vb;

    assign ra = raddr_a[AW*i +: AW];
    assign rb = raddr_b[AW*i +: AW];

    always_comb begin
      va = (ra == AW'(REG_ZERO)) ? '0 : regs[ra];
      vb = (rb == AW'(REG_ZERO)) ? '0 : regs[rb];
      for (int p = 0; p < NPORTS; p++) begin
        if (we[p] && waddr[AW*p +: AW] == ra && ra != AW'(REG_ZERO))
          va = wdata[XLEN*p +: XLEN];
        if (we[p] && waddr[AW*p +: AW] == rb && rb != AW'(REG_ZERO))
          vb = wdata[XLEN*p +: XLEN];
      end
    end

    assign rdata_a[XLEN*i +: XLEN] = va;
    assign rdata_b[XLEN*i +: XLEN] = vb;
  end

endmodule

// File: rtl/decode_nway.sv
// N-lane decode stage: regfile read, forwarding, sign-extend, branch target
// and compare, registered D/E boundary. DECODE_JUMP_EN adds jtarget_d.
module decode_nway
  import decode_pkg::*;
#(
  parameter int NLANES = 2,
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int FW     = $clog2(NLANES+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NLANES*32-1:0]   instr_d,
  input  logic [NLANES-1:0]      valid_d,
  input  logic [XLEN-1:0]        pcplus4_d,
  input  logic [NLANES-1:0]      regwrite_w,
  input  logic [NLANES*AW-1:0]   writereg_w,
  input  logic [NLANES*XLEN-1:0] result_w,
  input  logic [NLANES*XLEN-1:0] aluout_m,
  input  logic [NLANES*FW-1:0]   fwd_a_d,
  input  logic [NLANES*FW-1:0]   fwd_b_d,
  input  logic                   hold_e,
  input  logic                   flush_e,
  output logic [NLANES*XLEN-1:0] pcbranch_d,
  output logic [NLANES-1:0]      equal_d,
  output logic [NLANES-1:0]      valid_e,
  output logic [NLANES*5-1:0]    rs_e,
  output logic [NLANES*5-1:0]    rt_e,
  output logic [NLANES*5-1:0]    rd_e,
  output logic [NLANES*XLEN-1:0] srca_e,
  output logic [NLANES*XLEN-1:0] srcb_e,
  output logic [NLANES*XLEN-1:0] signimm_e
`ifdef DECODE_JUMP_EN
  ,
  output logic [NLANES*XLEN-1:0] jtarget_d
`endif
);

  localparam int RS_W = RS_MSB - RS_LSB + 1;
  localparam int RT_W = RT_MSB - RT_LSB + 1;
  localparam int RD_W = RD_MSB - RD_LSB + 1;

  logic [NLANES*AW-1:0]   rs_addr, rt_addr;
  logic [NLANES*XLEN-1:0] rf_a, rf_b, srca_d, srcb_d, signimm_d;
  logic [NLANES-1:0]      unused_opcode;

  decode_regfile_mp #(
    .NPORTS (NLANES),
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (regwrite_w),
    .waddr   (writereg_w),
    .wdata   (result_w),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    logic [31:0]     instr;
    logic [XLEN-1:0] pc4, imm, srca, srcb;
    logic [FW-1:0]   sel_a, sel_b;

    assign instr         = instr_d[32*i +: 32];
    assign sel_a         = fwd_a_d[FW*i +: FW];
    assign sel_b         = fwd_b_d[FW*i +: FW];
    assign rs_addr[AW*i +: AW] = instr[RS_LSB +: AW];
    assign rt_addr[AW*i +: AW] = instr[RT_LSB +: AW];
    assign unused_opcode[i]    = ^instr[31:26];

    assign imm = {{(XLEN-16){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    assign pc4 = pcplus4_d + XLEN'(4*i);

    // Out-of-range selects fall back to the regfile value.
    always_comb begin
      if (sel_a == FW'(FWD_RF) || int'(sel_a) > NLANES) srca = rf_a[XLEN*i +: XLEN];
      else srca = aluout_m[XLEN*(int'(sel_a) - FWD_M_BASE) +: XLEN];
      if (sel_b == FW'(FWD_RF) || int'(sel_b) > NLANES) srcb = rf_b[XLEN*i +: XLEN];
      else srcb = aluout_m[XLEN*(int'(sel_b) - FWD_M_BASE) +: XLEN];
    end

    assign srca_d[XLEN*i +: XLEN]     = srca;
    assign srcb_d[XLEN*i +: XLEN]     = srcb;
    assign signimm_d[XLEN*i +: XLEN]  = imm;
    assign pcbranch_d[XLEN*i +: XLEN] = pc4 + (imm << 2);
    assign equal_d[i]                 = (srca == srcb);

`ifdef DECODE_JUMP_EN
    assign jtarget_d[XLEN*i +: XLEN] = {pc4[XLEN-1:28], instr[25:0], 2'b00};
`endif
  end

  // D/E boundary: flush beats hold beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_e) begin
      valid_e   <= '0;
      rs_e      <= '0;
      rt_e      <= '0;
      rd_e      <= '0;
      srca_e    <= '0;
      srcb_e    <= '0;
      signimm_e <= '0;
    end else if (!hold_e) begin
      valid_e   <= valid_d;
      srca_e    <= srca_d;
      srcb_e    <= srcb_d;
      signimm_e <= signimm_d;
      for (int i = 0; i < NLANES; i++) begin
        rs_e[5*i +: 5] <= instr_d[32*i + RS_LSB +: RS_W];
        rt_e[5*i +: 5] <= instr_d[32*i + RT_LSB +: RT_W];
        rd_e[5*i +: 5] <= instr_d[32*i + RD_LSB +: RD_W];
      end
    end
  end

endmodule

// File: tb/tb_decode_nway.sv
// Self-checking bench for decode_nway (2 lanes, 32-bit): directed scenarios
// plus randomized traffic against a behavioural model of the decode stage.
module tb_decode_nway;

  localparam int NL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] instr_d;
  logic [1:0]  valid_d;
  logic [31:0] pcplus4_d;
  logic [1:0]  regwrite_w;
  logic [9:0]  writereg_w;
  logic [63:0] result_w, aluout_m;
  logic [3:0]  fwd_a_d, fwd_b_d;
  logic        hold_e, flush_e;
  logic [63:0] pcbranch_d;
  logic [1:0]  equal_d, valid_e;
  logic [9:0]  rs_e, rt_e, rd_e;
  logic [63:0] srca_e, srcb_e, signimm_e;
`ifdef DECODE_JUMP_EN
  logic [63:0] jtarget_d;
`endif

  decode_nway #(.NLANES(NL), .XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .pcplus4_d(pcplus4_d), .regwrite_w(regwrite_w), .writereg_w(writereg_w),
    .result_w(result_w), .aluout_m(aluout_m), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .hold_e(hold_e), .flush_e(flush_e), .pcbranch_d(pcbranch_d), .equal_d(equal_d),
    .valid_e(valid_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .srca_e(srca_e), .srcb_e(srcb_e), .signimm_e(signimm_e)
`ifdef DECODE_JUMP_EN
    , .jtarget_d(jtarget_d)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: architectural registers and expected E contents.
  logic [31:0] rf [32];
  logic [1:0]  x_valid;
  logic [9:0]  x_rs, x_rt, x_rd;
  logic [63:0] x_srca, x_srcb, x_imm;

  function automatic logic [31:0] mk(input int rs, input int rt, input int imm);
    return {6'd0, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : rf[a];
    for (int w = 0; w < NL; w++)
      if (regwrite_w[w] && writereg_w[5*w +: 5] == a && a != 5'd0) v = result_w[32*w +: 32];
    return v;
  endfunction

  function automatic logic [31:0] src_val(input int sel, input logic [4:0] a);
    if (sel >= 1 && sel <= NL) return aluout_m[32*(sel-1) +: 32];
    return rf_read(a);
  endfunction

  function automatic logic [31:0] branch_target(input int lane);
    int off;
    off = $signed(instr_d[32*lane +: 16]);
    return pcplus4_d + 32'(4*lane) + 32'(off * 4);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) rf[r] = '0;
    x_valid = '0; x_rs = '0; x_rt = '0; x_rd = '0;
    x_srca = '0;  x_srcb = '0; x_imm = '0;
  endtask

  task automatic clear_inputs();
    instr_d = '0; valid_d = '0; pcplus4_d = '0; regwrite_w = '0; writereg_w = '0;
    result_w = '0; aluout_m = '0; fwd_a_d = '0; fwd_b_d = '0; hold_e = 0; flush_e = 0;
  endtask

  // Advance one clock: predict the E register, then commit W writes to the model.
  task automatic tick();
    logic [1:0]  nv;
    logic [9:0]  nrs, nrt, nrd;
    logic [63:0] nsa, nsb, nim;
    nv = x_valid; nrs = x_rs; nrt = x_rt; nrd = x_rd; nsa = x_srca; nsb = x_srcb; nim = x_imm;
    if (flush_e) begin
      nv = '0; nrs = '0; nrt = '0; nrd = '0; nsa = '0; nsb = '0; nim = '0;
    end else if (!hold_e) begin
      nv = valid_d;
      for (int i = 0; i < NL; i++) begin
        logic [31:0] ins;
        int off;
        ins = instr_d[32*i +: 32];
        nrs[5*i +: 5]  = ins[25:21];
        nrt[5*i +: 5]  = ins[20:16];
        nrd[5*i +: 5]  = ins[15:11];
        nsa[32*i +: 32] = src_val(int'(fwd_a_d[2*i +: 2]), ins[25:21]);
        nsb[32*i +: 32] = src_val(int'(fwd_b_d[2*i +: 2]), ins[20:16]);
        off = $signed(ins[15:0]);
        nim[32*i +: 32] = 32'(off);
      end
    end
    @(posedge clk);
    x_valid = nv; x_rs = nrs; x_rt = nrt; x_rd = nrd; x_srca = nsa; x_srcb = nsb; x_imm = nim;
    for (int w = 0; w < NL; w++)
      if (regwrite_w[w] && writereg_w[5*w +: 5] != 5'd0) rf[writereg_w[5*w +: 5]] = result_w[32*w +: 32];
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NL; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      instr_d[32*i +: 32]   = ins;
      writereg_w[5*i +: 5]  = 5'($urandom_range(0, 7));
      result_w[32*i +: 32]  = $urandom;
      aluout_m[32*i +: 32]  = $urandom;
      fwd_a_d[2*i +: 2]     = 2'($urandom_range(0, 3));
      fwd_b_d[2*i +: 2]     = 2'($urandom_range(0, 3));
    end
    valid_d    = 2'($urandom_range(0, 3));
    regwrite_w = 2'($urandom_range(0, 3));
    pcplus4_d  = $urandom;
    hold_e     = ($urandom_range(0, 7) == 0);
    flush_e    = ($urandom_range(0, 15) == 0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    #2;
    checks++;
    if ({valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e} !== 224'd0) begin
      failures++; $display("FAIL reset_e_outputs got=%h exp=0", {valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e});
    end
    checks++;
    if (pcbranch_d !== 64'h00000004_00000000) begin
      failures++; $display("FAIL reset_pcbranch got=%h exp=%h", pcbranch_d, 64'h00000004_00000000);
    end
    checks++;
    if (equal_d !== 2'b11) begin
      failures++; $display("FAIL reset_equal got=%b exp=11", equal_d);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_write_through();
    clear_inputs();
    valid_d = 2'b11;
    instr_d = {mk(5, 0, 0), mk(0, 0, 0)};
    regwrite_w = 2'b01; writereg_w = {5'd0, 5'd5}; result_w = {32'd0, 32'h1234};
    tick();
    checks++;
    if (srca_e[63:32] !== 32'h1234) begin
      failures++; $display("FAIL wt_lane1_rs got=%h exp=%h", srca_e[63:32], 32'h1234);
    end
    instr_d = {mk(0, 0, 0), mk(5, 5, 0)};
    regwrite_w = 2'b11; writereg_w = {5'd5, 5'd5}; result_w = {32'hBBBB, 32'hAAAA};
    tick();
    checks++;
    if ({srca_e[31:0], srcb_e[31:0]} !== {32'hBBBB, 32'hBBBB}) begin
      failures++; $display("FAIL wt_same_reg got=%h/%h exp=0000bbbb", srca_e[31:0], srcb_e[31:0]);
    end
    regwrite_w = 2'b00;
    tick();
    checks++;
    if (srca_e[31:0] !== 32'hBBBB) begin
      failures++; $display("FAIL rf_priority_stored got=%h exp=%h", srca_e[31:0], 32'hBBBB);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    instr_d = {mk(3, 4, 0), mk(1, 2, 0)};
    aluout_m = {32'hDEAD, 32'hBEEF};
    fwd_a_d = 4'b0010; fwd_b_d = 4'b0100;
    tick();
    checks++;
    if (srca_e[31:0] !== 32'hDEAD) begin
      failures++; $display("FAIL fwd_a_lane0 got=%h exp=%h", srca_e[31:0], 32'hDEAD);
    end
    checks++;
    if (srcb_e[63:32] !== 32'hBEEF) begin
      failures++; $display("FAIL fwd_b_lane1 got=%h exp=%h", srcb_e[63:32], 32'hBEEF);
    end
    fwd_a_d = 4'b0011; fwd_b_d = 4'b0000;
    regwrite_w = 2'b01; writereg_w = {5'd0, 5'd1}; result_w = {32'd0, 32'h77};
    tick();
    checks++;
    if (srca_e[31:0] !== 32'h77) begin
      failures++; $display("FAIL fwd_out_of_range got=%h exp=%h", srca_e[31:0], 32'h77);
    end
    instr_d = {mk(0, 0, 0), mk(0, 0, 0)};
    fwd_a_d = 4'b0000;
    regwrite_w = 2'b01; writereg_w = {5'd0, 5'd0}; result_w = {32'd0, 32'hFFFF};
    tick();
    checks++;
    if (srca_e[31:0] !== 32'd0) begin
      failures++; $display("FAIL r0_write_through got=%h exp=0", srca_e[31:0]);
    end
    regwrite_w = 2'b00;
    tick();
    checks++;
    if (srca_e[31:0] !== 32'd0) begin
      failures++; $display("FAIL r0_stored got=%h exp=0", srca_e[31:0]);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    pcplus4_d = 32'h100;
    instr_d = {mk(0, 0, 16'hFFFF), mk(0, 0, 16'h0010)};
    #1;
    checks++;
    if (pcbranch_d !== {32'h100, 32'h140}) begin
      failures++; $display("FAIL branch_target got=%h exp=%h", pcbranch_d, {32'h100, 32'h140});
    end
    instr_d = {mk(0, 0, 0), mk(1, 2, 0)};
    aluout_m = {32'd7, 32'd7}; fwd_a_d = 4'b0001; fwd_b_d = 4'b0010;
    #1;
    checks++;
    if (equal_d !== 2'b11) begin
      failures++; $display("FAIL equal_same got=%b exp=11", equal_d);
    end
    aluout_m = {32'd8, 32'd7};
    #1;
    checks++;
    if (equal_d !== 2'b10) begin
      failures++; $display("FAIL equal_diff got=%b exp=10", equal_d);
    end
    tick();
  endtask

  task automatic test_hold_flush();
    logic [223:0] snap;
    clear_inputs();
    rand_inputs();
    hold_e = 0; flush_e = 0; valid_d = 2'b11;
    tick();
    snap = {valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e};
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      hold_e = 1; flush_e = 0;
      tick();
      checks++;
      if ({valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e} !== snap) begin
        failures++; $display("FAIL hold_cycle%0d got=%h exp=%h", c, {valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e}, snap);
      end
    end
    hold_e = 1; flush_e = 1;
    tick();
    checks++;
    if ({valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e} !== 224'd0) begin
      failures++; $display("FAIL flush_over_hold got=%h exp=0", {valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e});
    end
    hold_e = 0; flush_e = 0;
  endtask

  task automatic test_random();
    logic [63:0] xb;
    logic [1:0]  xe;
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      #1;
      for (int i = 0; i < NL; i++) begin
        xb[32*i +: 32] = branch_target(i);
        xe[i] = (src_val(int'(fwd_a_d[2*i +: 2]), instr_d[32*i+21 +: 5]) ==
                 src_val(int'(fwd_b_d[2*i +: 2]), instr_d[32*i+16 +: 5]));
      end
      checks++;
      if (pcbranch_d !== xb) begin
        failures++; $display("FAIL rand_pcbranch n=%0d got=%h exp=%h", n, pcbranch_d, xb);
      end
      checks++;
      if (equal_d !== xe) begin
        failures++; $display("FAIL rand_equal n=%0d got=%b exp=%b", n, equal_d, xe);
      end
      tick();
      checks++;
      if ({valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e} !==
          {x_valid, x_rs, x_rt, x_rd, x_srca, x_srcb, x_imm}) begin
        failures++; $display("FAIL rand_e_reg n=%0d got=%h exp=%h", n,
          {valid_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e}, {x_valid, x_rs, x_rt, x_rd, x_srca, x_srcb, x_imm});
      end
    end
    hold_e = 0; flush_e = 0;
  endtask

  task automatic test_reset_midrun();
    clear_inputs();
    valid_d = 2'b11;
    instr_d = {mk(0, 0, 0), mk(5, 0, 0)};
    regwrite_w = 2'b01; writereg_w = {5'd0, 5'd5}; result_w = {32'd0, 32'h5555};
    tick();
    checks++;
    if ({valid_e, srca_e[31:0], rs_e[4:0]} !== {2'b11, 32'h5555, 5'd5}) begin
      failures++; $display("FAIL midrun_preload got=%b/%h/%0d exp=11/5555/5", valid_e, srca_e[31:0], rs_e[4:0]);
    end
    regwrite_w = 2'b00;
    rst_n = 0;
    #1;
    checks++;
    if ({valid_e, srca_e, rs_e} !== 76'd0) begin
      failures++; $display("FAIL midrun_async_clear got=%b/%h/%h exp=0", valid_e, srca_e, rs_e);
    end
    model_reset();
    #2;
    rst_n = 1;
    tick();
    checks++;
    if (srca_e[31:0] !== 32'd0) begin
      failures++; $display("FAIL midrun_r5_cleared got=%h exp=0", srca_e[31:0]);
    end
  endtask

`ifdef DECODE_JUMP_EN
  task automatic test_jump();
    clear_inputs();
    pcplus4_d = 32'h10000004;
    instr_d = {32'h03FFFFFF, 32'h00000010};
    #1;
    checks++;
    if (jtarget_d !== {32'h1FFFFFFC, 32'h10000040}) begin
      failures++; $display("FAIL jump_target got=%h exp=%h", jtarget_d, {32'h1FFFFFFC, 32'h10000040});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_through();
    test_forwarding();
    test_branch();
    test_hold_flush();
    test_random();
    test_reset_midrun();
`ifdef DECODE_JUMP_EN
    test_jump();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
